// File: rtl/hub75_rx.sv
// HUB75 panel receiver: synchronizes the panel bus into clk, assembles one row of
// shifted pixels and dumps it into frame memory after each latch strobe.

module hub75_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst)
    if (!rst) ff <= '0;
    else      ff <= {ff[STAGES-2:0], d};

  assign q = ff[STAGES-1];
endmodule

module hub75_rx #(
  parameter int WIDTH    = 32,
  parameter int ROW_BITS = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              CLK_M,
  input  logic                              R1,
  input  logic                              G1,
  input  logic                              B1,
  input  logic                              R2,
  input  logic                              G2,
  input  logic                              B2,
  input  logic                              A,
  input  logic                              B,
  input  logic                              LAT,
  input  logic                              OE,
  input  logic                              clr_err,
  output logic                              wr_en,
  output logic [ROW_BITS+$clog2(WIDTH)-1:0] wr_addr,
  output logic [5:0]                        wr_data,
  output logic                              row_done,
  output logic                              frame_done,
  output logic                              err_short,
  output logic                              err_long,
  output logic                              err_overrun,
  output logic [15:0]                       blank_cycles
);
  localparam int CB = $clog2(WIDTH);
  localparam int NS = 11;

  typedef enum logic {SHIFT, DUMP} state_t;

  logic [NS-1:0] async_in, sync_in;
  logic          s_clkm, s_lat, s_oe;
  logic [5:0]    s_pix;
  logic [1:0]    s_ba;

  assign async_in = {OE, LAT, B, A, R1, G1, B1, R2, G2, B2, CLK_M};

  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_sync
      hub75_sync #(.STAGES(2)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (async_in[gi]),
        .q   (sync_in[gi])
      );
    end
  endgenerate

  assign s_clkm = sync_in[0];
  assign s_pix  = sync_in[6:1];
  assign s_ba   = sync_in[8:7];
  assign s_lat  = sync_in[9];
  assign s_oe   = sync_in[10];

  // The chain's reset zeros are not real samples: only arm CLK_M edge detection
  // once a genuine low has propagated through both stages.
  logic       clkm_d3, lat_d3, armed;
  logic [1:0] fill;
  logic       clkm_rise, lat_rise;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      clkm_d3 <= 1'b0;
      lat_d3  <= 1'b0;
      fill    <= '0;
      armed   <= 1'b0;
    end else begin
      clkm_d3 <= s_clkm;
      lat_d3  <= s_lat;
      fill    <= {fill[0], 1'b1};
      armed   <= armed | (fill[1] & ~s_clkm);
    end

  assign clkm_rise = s_clkm & ~clkm_d3 & armed;
  assign lat_rise  = s_lat & ~lat_d3;

  state_t                  state, state_nx;
  logic [CB:0]             cnt, cnt_nx;
  logic                    ovf, ovf_nx;
  logic [WIDTH-1:0][5:0]   rowbuf, rowbuf_nx, snap;
  logic [ROW_BITS-1:0]     row_q;
  logic [CB-1:0]           col;
  logic [15:0]             blank_cnt;
  logic                    lat_take, last_wr;
  logic                    set_short, set_long, set_ovr;

  // Same-cycle capture lands before the latch, so snapshot and error checks use *_nx.
  always_comb begin
    rowbuf_nx = rowbuf;
    cnt_nx    = cnt;
    ovf_nx    = ovf;
    if (clkm_rise) begin
      if (cnt == (CB+1)'(WIDTH)) ovf_nx = 1'b1;
      else begin
        rowbuf_nx[~cnt[CB-1:0]] = s_pix;
        cnt_nx = cnt + 1'b1;
      end
    end
  end

  assign lat_take  = lat_rise && (state == SHIFT);
  assign last_wr   = (state == DUMP) && (col == CB'(WIDTH-1));
  assign set_long  = (clkm_rise && cnt == (CB+1)'(WIDTH)) || (lat_take && ovf_nx);
  assign set_short = lat_take && !ovf_nx && (cnt_nx != (CB+1)'(WIDTH));
  assign set_ovr   = lat_rise && (state == DUMP);

  always_ff @(posedge clk) begin
    rowbuf <= rowbuf_nx;
    if (lat_take) snap <= rowbuf_nx;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt          <= '0;
      ovf          <= 1'b0;
      row_q        <= '0;
      col          <= '0;
      blank_cnt    <= '0;
      blank_cycles <= '0;
      row_done     <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      cnt        <= lat_take ? '0 : cnt_nx;
      ovf        <= lat_take ? 1'b0 : ovf_nx;
      col        <= (state == DUMP) ? col + 1'b1 : '0;
      row_done   <= last_wr;
      frame_done <= last_wr && (&row_q);
      if (lat_take) begin
        row_q        <= ROW_BITS'(s_ba);
        blank_cycles <= blank_cnt;
        blank_cnt    <= '0;
      end else if (s_oe && blank_cnt != 16'hFFFF) begin
        blank_cnt <= blank_cnt + 1'b1;
      end
    end

  // Error events win over a simultaneous clear.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (set_short)    err_short <= 1'b1;
      else if (clr_err) err_short <= 1'b0;
      if (set_long)     err_long <= 1'b1;
      else if (clr_err) err_long <= 1'b0;
      if (set_ovr)      err_overrun <= 1'b1;
      else if (clr_err) err_overrun <= 1'b0;
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= SHIFT;
    else      state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      SHIFT:   if (lat_take) state_nx = DUMP;
      DUMP:    if (last_wr)  state_nx = SHIFT;
      default: state_nx = SHIFT;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (state == DUMP) begin
      wr_en   = 1'b1;
      wr_addr = {row_q, col};
      wr_data = snap[col];
    end
  end
endmodule

// File: tb/tb_hub75_rx.sv
// Randomized bench for hub75_rx against a pixel-level model of row assembly and dumps.
module tb_hub75_rx;
  localparam int W  = 32;
  localparam int RB = 2;
  localparam int CB = $clog2(W);
  localparam int AW = RB + CB;

  logic clk = 1'b0, rst = 1'b0;
  logic CLK_M = 1'b1, R1 = 1'b0, G1 = 1'b0, B1 = 1'b0, R2 = 1'b0, G2 = 1'b0, B2 = 1'b0;
  logic A = 1'b0, B = 1'b0, LAT = 1'b0, OE = 1'b0, clr_err = 1'b0;
  logic          wr_en, row_done, frame_done, err_short, err_long, err_overrun;
  logic [AW-1:0] wr_addr;
  logic [5:0]    wr_data;
  logic [15:0]   blank_cycles;

  always #5 clk = ~clk;

  hub75_rx #(.WIDTH(W), .ROW_BITS(RB)) dut (
    .clk(clk), .rst(rst), .CLK_M(CLK_M),
    .R1(R1), .G1(G1), .B1(B1), .R2(R2), .G2(G2), .B2(B2),
    .A(A), .B(B), .LAT(LAT), .OE(OE), .clr_err(clr_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .row_done(row_done), .frame_done(frame_done),
    .err_short(err_short), .err_long(err_long), .err_overrun(err_overrun),
    .blank_cycles(blank_cycles)
  );

  int checks = 0, errors = 0;
  logic [AW+5:0] obs_q[$], exp_q[$];
  int rd_cnt = 0, fd_cnt = 0, rd_bad = 0;
  bit last_wr = 1'b0;

  // Model: panel shift register contents and pixel count since the last accepted latch.
  logic [5:0] mdl_buf[W];
  int mdl_cnt = 0;
  bit mdl_ovf = 1'b0;
  bit exp_short = 1'b0, exp_long = 1'b0;

  always @(negedge clk) begin
    if (wr_en) obs_q.push_back({wr_addr, wr_data});
    if (row_done) rd_cnt++;
    if (frame_done) fd_cnt++;
    if ((row_done != last_wr) || (frame_done && !row_done)) rd_bad++;
    last_wr = wr_en && (wr_addr[CB-1:0] == CB'(W-1));
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shift_pixel(input logic [5:0] p);
    {R1, G1, B1, R2, G2, B2} = p;
    CLK_M = 1'b0;
    cycles(3);
    CLK_M = 1'b1;
    cycles(3);
    if (mdl_cnt < W) begin
      mdl_buf[W-1-mdl_cnt] = p;
      mdl_cnt++;
    end else begin
      mdl_ovf  = 1'b1;
      exp_long = 1'b1;
    end
  endtask

  task automatic latch(input logic [1:0] r);
    logic [CB-1:0] cc;
    {B, A} = r;
    cycles(1);
    LAT = 1'b1;
    cycles(3);
    LAT = 1'b0;
    cycles(1);
    for (int c = 0; c < W; c++) begin
      cc = CB'(c);
      exp_q.push_back({r, cc, mdl_buf[c]});
    end
    if (mdl_ovf) exp_long = 1'b1;
    else if (mdl_cnt != W) exp_short = 1'b1;
    mdl_cnt = 0;
    mdl_ovf = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    cycles(5);
    checks++;
    if ({wr_en, row_done, frame_done, err_short, err_long, err_overrun} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got %b want 000000",
        {wr_en, row_done, frame_done, err_short, err_long, err_overrun});
    end
    checks++;
    if (wr_addr !== '0 || wr_data !== '0) begin
      errors++; $display("FAIL reset_wr got %h/%h want 0/0", wr_addr, wr_data);
    end
    checks++;
    if (blank_cycles !== 16'd0) begin
      errors++; $display("FAIL reset_blank got %0d want 0", blank_cycles);
    end
    rst = 1'b1;  // CLK_M is high here: release must not register an edge
    cycles(5);
  endtask

  task automatic test_pattern;
    logic [AW+5:0] want;
    for (int k = 0; k < W; k++) shift_pixel(6'(k));
    latch(2'b01);
    cycles(50);
    checks++;
    if (obs_q.size() != W) begin
      errors++; $display("FAIL pattern_count got %0d want %0d", obs_q.size(), W);
    end else begin
      for (int i = 0; i < W; i++) begin
        want = {AW'(32 + i), 6'(31 - i)};
        checks++;
        if (obs_q[i] !== want) begin
          errors++; $display("FAIL pattern_wr[%0d] got %h want %h", i, obs_q[i], want);
        end
      end
    end
    checks++;
    if (rd_cnt != 1 || fd_cnt != 0 || rd_bad != 0) begin
      errors++; $display("FAIL pattern_done got rd=%0d fd=%0d bad=%0d want 1/0/0", rd_cnt, fd_cnt, rd_bad);
    end
    checks++;
    if ({err_short, err_long, err_overrun} !== 3'b0) begin
      errors++; $display("FAIL pattern_err got %b want 000", {err_short, err_long, err_overrun});
    end
    obs_q.delete(); exp_q.delete();
  endtask

  // Next row is shifted while the previous one is still dumping.
  task automatic test_frame;
    int rd0, fd0;
    rd0 = rd_cnt; fd0 = fd_cnt;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < W; k++) shift_pixel(6'($urandom));
      if (r == 3) begin
        checks++;
        if (fd_cnt != fd0) begin
          errors++; $display("FAIL frame_early got %0d want %0d", fd_cnt, fd0);
        end
      end
      latch(2'(r));
    end
    cycles(50);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL frame_count got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL frame_wr[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (rd_cnt - rd0 != 4 || fd_cnt - fd0 != 1 || rd_bad != 0) begin
      errors++; $display("FAIL frame_done got rd=%0d fd=%0d bad=%0d want 4/1/0", rd_cnt - rd0, fd_cnt - fd0, rd_bad);
    end
    checks++;
    if ({err_short, err_long, err_overrun} !== 3'b0) begin
      errors++; $display("FAIL frame_err got %b want 000", {err_short, err_long, err_overrun});
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_short_long(input int npix, input string tag);
    for (int k = 0; k < npix; k++) shift_pixel(6'($urandom));
    latch(2'($urandom));
    cycles(50);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL %s_count got %0d want %0d", tag, obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL %s_wr[%0d] got %h want %h", tag, i, obs_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if ({err_short, err_long, err_overrun} !== {exp_short, exp_long, 1'b0}) begin
      errors++; $display("FAIL %s_err got %b want %b", tag,
        {err_short, err_long, err_overrun}, {exp_short, exp_long, 1'b0});
    end
    clr_err = 1'b1;
    cycles(1);
    clr_err = 1'b0;
    cycles(1);
    exp_short = 1'b0; exp_long = 1'b0;
    checks++;
    if ({err_short, err_long, err_overrun} !== 3'b0) begin
      errors++; $display("FAIL %s_clr got %b want 000", tag, {err_short, err_long, err_overrun});
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_overrun;
    for (int k = 0; k < W; k++) shift_pixel(6'($urandom));
    latch(2'($urandom));
    cycles(10);
    {B, A} = 2'($urandom);
    LAT = 1'b1;
    cycles(3);
    LAT = 1'b0;
    cycles(80);
    checks++;
    if (err_overrun !== 1'b1 || err_short !== 1'b0 || err_long !== 1'b0) begin
      errors++; $display("FAIL overrun_err got %b want 001", {err_short, err_long, err_overrun});
    end
    checks++;
    if (obs_q.size() != W) begin
      errors++; $display("FAIL overrun_count got %0d want %0d", obs_q.size(), W);
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL overrun_wr[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    clr_err = 1'b1;
    cycles(1);
    clr_err = 1'b0;
    cycles(1);
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_blank;
    OE = 1'b1;
    cycles(100);
    OE = 1'b0;
    for (int k = 0; k < W; k++) shift_pixel(6'($urandom));
    latch(2'($urandom));
    cycles(50);
    checks++;
    if (blank_cycles !== 16'd100) begin
      errors++; $display("FAIL blank_cycles got %0d want 100", blank_cycles);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_rst_mid_dump;
    for (int k = 0; k < W; k++) shift_pixel(6'($urandom));
    latch(2'($urandom));
    for (int i = 0; i < 60 && obs_q.size() < 5; i++) cycles(1);
    checks++;
    if (obs_q.size() < 5) begin
      errors++; $display("FAIL rstdump_start got %0d writes want >=5", obs_q.size());
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({wr_en, row_done, frame_done, err_short, err_long, err_overrun} !== 6'b0) begin
      errors++; $display("FAIL rstdump_flags got %b want 000000",
        {wr_en, row_done, frame_done, err_short, err_long, err_overrun});
    end
    checks++;
    if (wr_addr !== '0 || wr_data !== '0 || blank_cycles !== 16'd0) begin
      errors++; $display("FAIL rstdump_outs got %h/%h/%0d want 0/0/0", wr_addr, wr_data, blank_cycles);
    end
    mdl_cnt = 0; mdl_ovf = 1'b0;
    obs_q.delete(); exp_q.delete();
    cycles(3);
    rst = 1'b1;
    cycles(50);
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL rstdump_writes got %0d want 0", obs_q.size());
    end
    checks++;
    if (rd_bad != 0) begin
      errors++; $display("FAIL done_timing got %0d bad pulses want 0", rd_bad);
    end
  endtask

  initial begin
    test_reset;
    test_pattern;
    test_frame;
    test_short_long(20, "short");
    test_short_long(W + 1, "long");
    test_overrun;
    test_blank;
    test_rst_mid_dump;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hub75_rx.md
HUB75_RX -- requirements
Module: hub75_rx

Interface
REQ-001 Parameter WIDTH, default 32: pixels per row (columns); power of two, at least 4.
REQ-002 Parameter ROW_BITS, default 2: width of the row address (A,B); rows per half-panel = 2^ROW_BITS.
REQ-003 Port clk  input  1: system clock, all logic on its rising edge; clk SHALL be at least 4x the CLK_M frequency.
REQ-004 Port rst  input  1: asynchronous, active-low reset.
REQ-005 Port CLK_M  input  1: HUB75 shift clock, asynchronous to clk.
REQ-006 Port R1,G1,B1,R2,G2,B2  input  1 each: HUB75 colour data for the upper and lower half, asynchronous.
REQ-007 Port A,B  input  1 each: HUB75 row address {B,A}, asynchronous.
REQ-008 Port LAT  input  1: HUB75 latch strobe, asynchronous.
REQ-009 Port OE  input  1: HUB75 output enable, active-low, asynchronous.
REQ-010 Port clr_err  input  1: synchronous clear of the sticky error flags.
REQ-011 Port wr_en  output  1: frame-memory write strobe.
REQ-012 Port wr_addr  output  ROW_BITS+log2(WIDTH): {row, col}.
REQ-013 Port wr_data  output  6: {R1,G1,B1,R2,G2,B2} for that pixel.
REQ-014 Port row_done  output  1: one-cycle pulse after the last write of a row dump.
REQ-015 Port frame_done  output  1: one-cycle pulse with row_done when the dumped row = 2^ROW_BITS-1.
REQ-016 Port err_short, err_long, err_overrun  output  1 each: sticky error flags.
REQ-017 Port blank_cycles  output  16: clk cycles OE was high (blanked) during the last completed row period; saturates at 0xFFFF.

Function
REQ-018 All asynchronous inputs SHALL pass through a 2-flop synchronizer; a third CLK_M flop and a third LAT flop SHALL provide edge detection.
REQ-019 A CLK_M rising edge (synchronized sample 1, previous sample 0) SHALL capture the six synchronized colour bits from the same stage.
REQ-020 An internal WIDTH x 6 row buffer SHALL store the k-th captured pixel after a latch (k = 0 first) at column WIDTH-1-k.
REQ-021 The shift counter SHALL count captured pixels from 0 and SHALL saturate at WIDTH; a capture at count WIDTH SHALL set err_long and SHALL discard the pixel.
REQ-022 The FSM SHALL have states SHIFT and DUMP; after reset it SHALL be in SHIFT.
REQ-023 In SHIFT, a LAT rising edge SHALL sample {B,A} as the row, snapshot the buffer into a dump register, clear the shift counter and enter DUMP on the next cycle.
REQ-024 A LAT rising edge with shift count not equal to WIDTH SHALL set err_short, or err_long if the count is saturated, and the row SHALL still be dumped; unwritten columns keep their previous contents.
REQ-025 In DUMP, the block SHALL assert wr_en for exactly WIDTH consecutive cycles with col = 0..WIDTH-1, wr_addr = {row, col} and wr_data = snapshot[col].
REQ-026 row_done, and frame_done where REQ-015 applies, SHALL pulse in the cycle after the last write; the FSM SHALL then return to SHIFT.
REQ-027 Pixels captured during DUMP SHALL be written to the live row buffer and counted normally, because the snapshot decouples dump from shift.
REQ-028 A LAT rising edge during DUMP SHALL set err_overrun and SHALL be ignored; the dump SHALL complete unchanged.
REQ-029 The blank counter SHALL increment each cycle synchronized OE = 1, SHALL transfer to blank_cycles and clear on each accepted LAT edge, and SHALL saturate at 0xFFFF.
REQ-030 A CLK_M and LAT edge detected in the same cycle: the pixel SHALL be captured first (counted in this row), then the latch SHALL be taken.
REQ-031 clr_err SHALL clear all three flags; an error event in the same cycle SHALL take priority, and the flag SHALL stay set.

Reset
REQ-032 While rst = 0: wr_en, row_done, frame_done and all error flags = 0; wr_addr = 0; wr_data = 0; blank_cycles = 0; counters = 0; FSM = SHIFT; synchronizer flops = 0.
REQ-033 Row buffer and snapshot contents are not reset; reset asserted mid-DUMP SHALL abort the dump with no further writes.
REQ-034 After release, the first CLK_M edge SHALL be detected only after the synchronizer has seen CLK_M low.

Verification
REQ-035 Shift 32 pixels of pattern k -> 6'(k), then LAT with {B,A} = 2'b01 -> 32 writes, addr 0x20..0x3F, data at col c = 6'(31-c), then one row_done and frame_done = 0.
REQ-036 Rows 0..3 each with 32 pixels -> row_done x4, frame_done only after row 3, no errors.
REQ-037 LAT after 20 pixels -> err_short = 1, 32 writes still issued; clr_err -> flag 0.
REQ-038 33 pixels then LAT -> err_long = 1; the 33rd pixel is absent from the memory image.
REQ-039 LAT edge 10 cycles into a dump -> err_overrun = 1; exactly 32 writes for the first row, none for the second.
REQ-040 OE high for 100 clk cycles within a row period -> blank_cycles = 100 after the next LAT; rst pulse mid-dump -> wr_en = 0 immediately, all outputs at reset values.
